alu_exec_unit: RTL and testbench

//  EX-stage datapath that consumes the 4-bit Operation code from ALUController plus the two ID/EX operands.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_shift_iter.sv | 79 +++++++
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU. The ALU controller and the
// execution unit both import this package, so the op-code values live in
// one place.
//   alu_op_e     : 4-bit ALU operation codes
//   exec_state_e : control states of the execution unit
//   is_shift_op  : true for the iterative shift operations
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,  // add, lw/sw address, auipc, addi
    OP_SUB = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_XOR = 4'b1001,
    OP_LUI = 4'b1010,  // pass srcb through
    OP_SLT = 4'b1100,  // slt and blt share this code
    OP_BNE = 4'b1101,
    OP_BGE = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } exec_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
// Iterative shifter. It holds the partially shifted accumulator and the
// remaining shift count, and moves the accumulator by up to SHIFT_STEP bits
// per step.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_start      : load i_data / i_shamt / i_op
//   i_step       : advance one step
//   i_kill       : abandon the current shift (count cleared)
//   i_op         : OP_SLL, OP_SRL or OP_SRA
//   i_data       : value to shift
//   i_shamt      : total shift amount
//   o_result     : accumulator after the step taken this cycle
//   o_done       : the step taken this cycle is the last one
// ---------------------------------------------------------------------------
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic                          i_step,
  input  logic                          i_kill,
  input  logic [3:0]                    i_op,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_shamt,
  output logic [DATA_WIDTH-1:0]         o_result,
  output logic                          o_done
);

  localparam int SHW = $clog2(DATA_WIDTH);
  // One extra bit so the count can be compared against SHIFT_STEP even when
  // SHIFT_STEP does not fit in the shift-amount field.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_op;

  logic [CW-1:0]         w_amt;
  logic [DATA_WIDTH-1:0] w_nxt;

  // The last step may be shorter than SHIFT_STEP.
  assign w_amt = (r_cnt < STEP_C) ? r_cnt : STEP_C;

  always_comb begin
    w_nxt = r_acc;
    case (r_op)
      OP_SLL:  w_nxt = r_acc << w_amt;
      OP_SRA:  w_nxt = $signed(r_acc) >>> w_amt;
      default: w_nxt = r_acc >> w_amt;
    endcase
  end

  assign o_result = w_nxt;
  assign o_done   = (r_cnt <= STEP_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_op  <= '0;
    end else if (i_kill) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_acc <= i_data;
      r_cnt <= {1'b0, i_shamt};
      r_op  <= i_op;
    end else if (i_step) begin
      r_acc <= w_nxt;
      r_cnt <= r_cnt - w_amt;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// EX-stage datapath. It takes the ALU op code and the two ID/EX operands and
// produces the registered result and branch condition for EX/MEM. Non-shift
// ops complete in one cycle. Shifts are iterative through alu_shift_iter.
// Both sides use a valid/ready handshake.
//   clk, reset_n        : clock, asynchronous active-low reset
//   flush               : synchronous kill of the in-flight op
//   in_valid / in_ready : upstream handshake (in_ready low stalls upstream)
//   operation           : alu_op_e code
//   srca, srcb          : operands; srcb low bits are the shift amount
//   out_valid/out_ready : downstream handshake
//   result, cond, zero  : registered result, branch condition, result == 0
//   illegal_op          : the op that produced result had an unmapped code
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cond,
  output logic                  zero,
  output logic                  illegal_op
);

  localparam int SHW = $clog2(DATA_WIDTH);

  exec_state_e           r_state;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_cond;
  logic                  r_zero;
  logic                  r_illegal;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [SHW-1:0]        w_shamt;
  logic                  w_start;
  logic                  w_step;
  logic [DATA_WIDTH-1:0] w_sh_result;
  logic                  w_sh_done;

  logic                  w_lt;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic                  w_alu_cond;
  logic                  w_alu_ill;

  // A held result can be replaced in the same cycle it is consumed.
  assign w_in_ready = !flush &&
                      ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
  assign w_accept   = in_valid && w_in_ready;
  assign w_shamt    = srcb[SHW-1:0];
  // A zero-amount shift takes the single-cycle path and returns srca.
  assign w_start    = w_accept && is_shift_op(operation) && (w_shamt != '0);
  assign w_step     = (r_state == SHIFT) && !flush;

  alu_shift_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_kill   (flush),
    .i_op     (operation),
    .i_data   (srca),
    .i_shamt  (w_shamt),
    .o_result (w_sh_result),
    .o_done   (w_sh_done)
  );

  // Single-cycle ALU.
  assign w_lt   = $signed(srca) < $signed(srcb);
  assign w_diff = srca - srcb;

  always_comb begin
    w_alu_res  = '0;
    w_alu_cond = 1'b0;
    w_alu_ill  = 1'b0;
    case (operation)
      OP_AND: w_alu_res = srca & srcb;
      OP_OR:  w_alu_res = srca | srcb;
      OP_XOR: w_alu_res = srca ^ srcb;
      OP_ADD: w_alu_res = srca + srcb;
      OP_SUB: w_alu_res = w_diff;
      OP_LUI: w_alu_res = srcb;
      OP_SLT: begin
        // slt writes the flag as a value; blt uses the same flag as cond.
        w_alu_res  = {{(DATA_WIDTH-1){1'b0}}, w_lt};
        w_alu_cond = w_lt;
      end
      OP_BEQ: begin
        w_alu_res  = w_diff;
        w_alu_cond = (srca == srcb);
      end
      OP_BNE: begin
        w_alu_res  = w_diff;
        w_alu_cond = (srca != srcb);
      end
      OP_BGE: begin
        w_alu_res  = w_diff;
        w_alu_cond = !w_lt;
      end
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = srca;
      default: w_alu_ill = 1'b1;
    endcase
  end

  // Control FSM. Result registers change only when HOLD is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cond      <= 1'b0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      // Accept happens from IDLE or from HOLD while the result is consumed.
      if (w_start) begin
        r_state     <= SHIFT;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= HOLD;
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_cond      <= w_alu_cond;
        r_zero      <= (w_alu_res == '0);
        r_illegal   <= w_alu_ill;
      end
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_sh_done) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_result    <= w_sh_result;
            r_cond      <= 1'b0;
            r_zero      <= (w_sh_result == '0);
            r_illegal   <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign cond       = r_cond;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int DW   = 32;
  localparam int STEP = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    operation;
  logic [DW-1:0] srca;
  logic [DW-1:0] srcb;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          cond;
  logic          zero;
  logic          illegal_op;

  alu_exec_unit #(.DATA_WIDTH(DW), .SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .cond       (cond),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        il;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the ALU rules written directly as arithmetic.
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic il);
    int sh;
    sh = int'(b[4:0]);
    r  = 32'h0;
    c  = 1'b0;
    il = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1001: r = a ^ b;
      4'b0010: r = a + b;
      4'b0011: r = a - b;
      4'b0100: r = a << sh;
      4'b0101: r = a >> sh;
      4'b0111: r = $signed(a) >>> sh;
      4'b1100: begin c = ($signed(a) < $signed(b)); r = {31'b0, c}; end
      4'b1010: r = b;
      4'b1000: begin r = a - b; c = (a == b); end
      4'b1101: begin r = a - b; c = (a != b); end
      4'b1110: begin r = a - b; c = ($signed(a) >= $signed(b)); end
      default: il = 1'b1;
    endcase
  endtask

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
      return 1 + (int'(b[4:0]) + STEP - 1) / STEP;
    return 1;
  endfunction

  // Issue one op from IDLE with out_ready high, wait for the result and
  // check it. Returns one cycle after the result retires (unit idle).
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ec,
                        input logic ei);
    int cyc;
    operation = op;
    srca      = a;
    srcb      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_inready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, ref_lat(op, b));
    chk({tag, "_result"}, result, er);
    chk({tag, "_cond"}, cond, ec);
    chk({tag, "_zero"}, zero, (er == 32'h0));
    chk({tag, "_illegal"}, illegal_op, ei);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] er;
    logic        ec, ei;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          lows, stray;

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = 4'h0;
    srca      = '0;
    srcb      = '0;

    // Table of directed vectors with hand-computed results.
    vq.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0});
    vq.push_back('{4'b0011, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0});
    vq.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
    vq.push_back('{4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0});
    vq.push_back('{4'b1001, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0});
    vq.push_back('{4'b1010, 32'h12345678, 32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0});
    vq.push_back('{4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0});
    vq.push_back('{4'b1100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
    vq.push_back('{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
    vq.push_back('{4'b1101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0});
    vq.push_back('{4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0});
    vq.push_back('{4'b1110, 32'h00000001, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0});
    vq.push_back('{4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0});
    vq.push_back('{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0});
    vq.push_back('{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0});
    vq.push_back('{4'b0100, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0});
    vq.push_back('{4'b0111, 32'h7FFFFFFF, 32'h00000023, 32'h0FFFFFFF, 1'b0, 1'b0});
    vq.push_back('{4'b1011, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
    vq.push_back('{4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1});
    vq.push_back('{4'b1111, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b1});

    // Reset state.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 32'h0);
    chk("rst_cond", cond, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal_op, 0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < vq.size(); i++)
      run_op($sformatf("vec%0d", i), vq[i].op, vq[i].a, vq[i].b, vq[i].res, vq[i].c, vq[i].il);

    // sra by 4: busy (in_ready low) for exactly 4 cycles, result on the 5th.
    operation = 4'b0111; srca = 32'h80000000; srcb = 32'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lows = 0;
    for (int c = 1; c <= 5; c++) begin
      if (!in_ready) lows++;
      if (c < 5) step();
    end
    chk("sra_inready_low_cycles", lows, 4);
    chk("sra_valid_cycle5", out_valid, 1);
    chk("sra_result", result, 32'hF8000000);
    step();

    // Back-to-back adds, then backpressure.
    operation = 4'b0010; srca = 32'd1; srcb = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("b2b1_valid", out_valid, 1);
    chk("b2b1_result", result, 32'd3);
    srca = 32'd10; srcb = 32'd20;
    step();
    chk("b2b2_valid", out_valid, 1);
    chk("b2b2_result", result, 32'd30);
    srca = 32'd100; srcb = 32'd200;
    step();
    chk("b2b3_valid", out_valid, 1);
    chk("b2b3_result", result, 32'd300);
    srca = 32'd7; srcb = 32'd8; out_ready = 1'b0;
    #1;
    chk("bp_inready", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", c), out_valid, 1);
      chk($sformatf("bp_hold%0d_result", c), result, 32'd300);
      chk($sformatf("bp_hold%0d_inready", c), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_inready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_next_result", result, 32'd15);
    step();
    chk("b2b_idle_valid", out_valid, 0);

    // Flush during a shift by 20.
    operation = 4'b0100; srca = 32'd1; srcb = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fl_shift_busy", in_ready, 0);
    step();
    step();
    flush = 1'b1; operation = 4'b0010; srca = 32'd40; srcb = 32'd2; in_valid = 1'b1;
    #1;
    chk("fl_inready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_result_held", result, 32'd15);
    #1;
    chk("fl_idle_inready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("fl_add_valid", out_valid, 1);
    chk("fl_add_result", result, 32'd42);
    step();
    stray = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) stray++;
      step();
    end
    chk("fl_no_stray_valid", stray, 0);

    // Flush while holding a result.
    operation = 4'b0010; srca = 32'd3; srcb = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("flh_valid", out_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flh_valid_dropped", out_valid, 0);
    chk("flh_result_held", result, 32'd7);
    out_ready = 1'b1;
    step();

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 4 == 0) rb = rb & 32'h0000000F;
      ref_alu(rop, ra, rb, er, ec, ei);
      run_op($sformatf("rnd%0d_op%0h", n, rop), rop, ra, rb, er, ec, ei);
    end

    // Reset asserted in the middle of a shift.
    operation = 4'b0111; srca = 32'h80000000; srcb = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("rms_out_valid", out_valid, 0);
    chk("rms_result", result, 32'h0);
    chk("rms_zero", zero, 1);
    step();
    #2 reset_n = 1'b1;
    step();
    chk("rms_inready", in_ready, 1);
    stray = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) stray++;
      step();
    end
    chk("rms_no_stray_valid", stray, 0);

    // Asynchronous reset while a result is held: out_valid drops at once.
    operation = 4'b0010; srca = 32'd3; srcb = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("rh_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rh_async_valid", out_valid, 0);
    chk("rh_async_result", result, 32'h0);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("rh_after_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
